// File: rtl/data_c_pipe_intc_m2s_robin_with_id.sv
// data_c_pipe_intc_m2s_robin_with_id: round-robin NUM-to-1 stream merge with sideband ID and one output register.
// Optional ROBIN_GRANT_CNT_EN adds saturating per-port accepted-beat counters on grant_cnt.
module data_c_pipe_intc_m2s_robin_with_id #(
   parameter int NUM    = 8,
   parameter int DSIZE  = 32,
   parameter int IDSIZE = 4
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [NUM-1:0]        s_valid,
   input  logic [NUM*DSIZE-1:0]  s_data,
   input  logic [NUM*IDSIZE-1:0] sid,
   output logic [NUM-1:0]        s_ready,
   output logic                  m_valid,
   output logic [DSIZE-1:0]      m_data,
   output logic [IDSIZE-1:0]     mid,
`ifdef ROBIN_GRANT_CNT_EN
   output logic [NUM*16-1:0]     grant_cnt,
`endif
   input  logic                  m_ready
);
   localparam int PW = NUM > 1 ? $clog2(NUM) : 1;
   logic [PW-1:0] ptr, gnt, cand;
   logic          gv, free, xfer;
   assign free = !m_valid || m_ready;
   assign xfer = free && gv;
   // scanning from the farthest candidate back lets the nearest valid port after ptr win
   always_comb begin
      gnt  = '0;
      gv   = 1'b0;
      cand = '0;
      for (int i = NUM; i >= 1; i--) begin
         cand = PW'((int'(ptr) + i) % NUM);
         if (s_valid[cand]) begin
            gnt = cand;
            gv  = 1'b1;
         end
      end
   end
   assign s_ready = (rst_n && xfer) ? NUM'(1) << gnt : '0;
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         mid     <= '0;
         ptr     <= PW'(NUM - 1);
      end else if (xfer) begin
         m_valid <= 1'b1;
         m_data  <= s_data[gnt*DSIZE +: DSIZE];
         mid     <= sid[gnt*IDSIZE +: IDSIZE];
         ptr     <= gnt;
      end else if (free) begin
         m_valid <= 1'b0;
      end
   end
`ifdef ROBIN_GRANT_CNT_EN
   for (genvar k = 0; k < NUM; k++) begin : g_cnt
      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n)
            grant_cnt[k*16 +: 16] <= '0;
         else if (s_valid[k] && s_ready[k] && grant_cnt[k*16 +: 16] != 16'hFFFF)
            grant_cnt[k*16 +: 16] <= grant_cnt[k*16 +: 16] + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_data_c_pipe_intc_m2s_robin_with_id.sv
// tb_data_c_pipe_intc_m2s_robin_with_id: directed and random checks of the round-robin merge against a queue-free reference model.
module tb_data_c_pipe_intc_m2s_robin_with_id;
   localparam int NUM = 4, DSIZE = 8, IDSIZE = 4;
   logic                  clock = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM-1:0]        s_valid = '0;
   logic [NUM*DSIZE-1:0]  s_data = '0;
   logic [NUM*IDSIZE-1:0] sid = '0;
   logic [NUM-1:0]        s_ready;
   logic                  m_valid;
   logic [DSIZE-1:0]      m_data;
   logic [IDSIZE-1:0]     mid;
   logic                  m_ready = 1'b1;
`ifdef ROBIN_GRANT_CNT_EN
   logic [NUM*16-1:0]     grant_cnt;
`endif
   int checks = 0, failures = 0;
   bit mv;
   logic [DSIZE-1:0] md;
   logic [IDSIZE-1:0] mi;
   int last;
   int cnt [NUM];

   data_c_pipe_intc_m2s_robin_with_id #(.NUM(NUM), .DSIZE(DSIZE), .IDSIZE(IDSIZE)) dut (
      .clock(clock), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .sid(sid),
      .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .mid(mid),
`ifdef ROBIN_GRANT_CNT_EN
      .grant_cnt(grant_cnt),
`endif
      .m_ready(m_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick();
      for (int i = 1; i <= NUM; i++)
         if (s_valid[(last + i) % NUM]) return (last + i) % NUM;
      return -1;
   endfunction

   task automatic model_reset();
      mv = 1'b0;
      md = '0;
      mi = '0;
      last = NUM - 1;
      for (int k = 0; k < NUM; k++) cnt[k] = 0;
   endtask

   task automatic step(input string tag);
      int g;
      bit free;
      logic [NUM-1:0] er;
      @(negedge clock);
      g = pick();
      free = !mv || m_ready;
      er = '0;
      if (free && g >= 0) er[g] = 1'b1;
      chk({tag, ".s_ready"}, 64'(s_ready), 64'(er));
      chk({tag, ".m_valid"}, 64'(m_valid), 64'(mv));
      chk({tag, ".m_data"}, 64'(m_data), 64'(md));
      chk({tag, ".mid"}, 64'(mid), 64'(mi));
`ifdef ROBIN_GRANT_CNT_EN
      for (int k = 0; k < NUM; k++) chk({tag, ".cnt"}, 64'(grant_cnt[k*16 +: 16]), 64'(cnt[k]));
`endif
      if (free) begin
         if (g >= 0) begin
            mv = 1'b1;
            md = s_data[g*DSIZE +: DSIZE];
            mi = sid[g*IDSIZE +: IDSIZE];
            last = g;
            if (cnt[g] < 65535) cnt[g]++;
         end else mv = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic fill();
      for (int k = 0; k < NUM; k++) begin
         s_data[k*DSIZE +: DSIZE] = DSIZE'($urandom);
         sid[k*IDSIZE +: IDSIZE] = IDSIZE'(k + 8);
      end
   endtask

   initial begin
      model_reset();
      s_valid = '1;
      fill();
      #12;
      chk("rst.m_valid", 64'(m_valid), 64'd0);
      chk("rst.mid", 64'(mid), 64'd0);
      chk("rst.m_data", 64'(m_data), 64'd0);
      chk("rst.s_ready", 64'(s_ready), 64'd0);
      s_valid = '0;
      @(posedge clock);
      #1 rst_n = 1'b1;
      step("idle");
      s_valid = '1;
      for (int n = 0; n < 5; n++) begin
         fill();
         step("rr");
         chk("rr.mid", 64'(mid), 64'(8 + (n % NUM)));
      end
      s_valid = 4'b0100;
      s_data[2*DSIZE +: DSIZE] = 8'hA5;
      sid[2*IDSIZE +: IDSIZE] = 4'h6;
      step("p2");
      chk("p2.data", 64'(m_data), 64'hA5);
      chk("p2.mid", 64'(mid), 64'h6);
      chk("p2.valid", 64'(m_valid), 64'd1);
      s_valid = '1;
      m_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         fill();
         step("hold");
         chk("hold.data", 64'(m_data), 64'hA5);
      end
      m_ready = 1'b1;
      step("release");
      s_valid = 4'b0010;
      step("p1");
      chk("p1.mid", 64'(mid), 64'(9));
      s_valid = 4'b1010;
      step("wrap3");
      chk("wrap3.mid", 64'(mid), 64'(11));
      step("wrap1");
      chk("wrap1.mid", 64'(mid), 64'(9));
      for (int n = 0; n < 400; n++) begin
         s_valid = NUM'($urandom);
         for (int k = 0; k < NUM; k++) begin
            s_data[k*DSIZE +: DSIZE] = DSIZE'($urandom);
            sid[k*IDSIZE +: IDSIZE] = IDSIZE'($urandom);
         end
         m_ready = ($urandom_range(0, 9) < 7);
         step("rand");
      end
      s_valid = '1;
      m_ready = 1'b0;
      step("pre_arst");
      @(negedge clock);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.m_valid", 64'(m_valid), 64'd0);
      chk("arst.s_ready", 64'(s_ready), 64'd0);
      model_reset();
      @(posedge clock);
      #1 rst_n = 1'b1;
      m_ready = 1'b1;
      s_valid = 4'b0001;
      for (int n = 0; n < 10; n++) step("cnt0");
      s_valid = 4'b0010;
      for (int n = 0; n < 3; n++) step("cnt1");
      s_valid = '0;
      step("cnt_idle");
`ifdef ROBIN_GRANT_CNT_EN
      chk("cnt.p0", 64'(grant_cnt[15:0]), 64'd10);
      chk("cnt.p1", 64'(grant_cnt[31:16]), 64'd3);
      rst_n = 1'b0;
      #1;
      chk("cnt.rst0", 64'(grant_cnt[15:0]), 64'd0);
      chk("cnt.rst1", 64'(grant_cnt[31:16]), 64'd0);
      model_reset();
      @(posedge clock);
      #1 rst_n = 1'b1;
      step("cnt_after");
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
